// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg: shared FSM state type and latency bounds for the memory responder
package memory_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
endpackage

// File: rtl/memory_array.sv
// memory_array: word storage with byte-masked synchronous write and combinational read
module memory_array #(
  parameter int WORDS = 1024,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clock,
  input  logic          write_enable,
  input  logic [AW-1:0] index,
  input  logic [31:0]   write_data,
  input  logic [3:0]    byte_enable,
  output logic [31:0]   read_data
);
  logic [31:0] r_mem [WORDS];
  always_ff @(posedge clock)
    for (int b = 0; b < 4; b++)
      if (write_enable && byte_enable[b]) r_mem[index][8*b +: 8] <= write_data[8*b +: 8];
  assign read_data = r_mem[index];
endmodule

// File: rtl/register.sv
// register: enable-loaded register with synchronous active-high clear
module register #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         write_enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock)
    if (reset) q <= '0;
    else if (write_enable) q <= d;
endmodule

// File: rtl/memory_responder.sv
// memory_responder: fixed-latency memory target with byte-masked writes and range checking
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int          WORDS   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_request,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_error
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                       (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [3:0] LOAD = 4'((LAT > 1) ? LAT - 2 : 0);
  state_t      r_state, w_next;
  logic [3:0]  r_count;
  logic        w_accept;
  logic [68:0] w_req_d, r_req, w_req;
  logic        w_write, w_in_range;
  logic [31:0] w_addr, w_data, w_offset, w_mem_rd;
  logic [3:0]  w_be;
  assign w_accept = (r_state == IDLE) && mem_request;
  assign w_req_d  = {mem_write, mem_address, mem_write_data, mem_byte_enable};
  register #(.W(69)) u_req (
    .clock(clock), .reset(reset), .write_enable(w_accept), .d(w_req_d), .q(r_req)
  );
  // With LATENCY=1 the response is entered on the accepting edge, before the latch holds the request.
  assign w_req = w_accept ? w_req_d : r_req;
  assign {w_write, w_addr, w_data, w_be} = w_req;
  assign w_offset   = w_addr - BASE;
  assign w_in_range = w_offset < (32'(WORDS) * 32'd4);
  memory_array #(.WORDS(WORDS), .AW(AW)) u_mem (
    .clock(clock),
    .write_enable((r_state == RESPOND) && w_write && w_in_range && !reset),
    .index(w_offset[AW+1:2]),
    .write_data(w_data),
    .byte_enable(w_be),
    .read_data(w_mem_rd)
  );
  always_comb
    w_next = (r_state == IDLE) ? (mem_request ? ((LAT > 1) ? WAIT : RESPOND) : IDLE) :
             (r_state == WAIT) ? ((r_count == 4'd0) ? RESPOND : WAIT) : IDLE;
  always_ff @(posedge clock)
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= 4'd0;
      mem_read_data <= 32'h0;
    end else begin
      r_state <= w_next;
      r_count <= w_accept ? LOAD : ((r_state == WAIT) && (r_count != 4'd0)) ? r_count - 4'd1 : r_count;
      if ((w_next == RESPOND) && !w_write) mem_read_data <= w_in_range ? w_mem_rd : 32'h0;
    end
  assign mem_ready = r_state == RESPOND;
  assign mem_error = mem_ready && !w_in_range;
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to mem_ready (legal 1..15).
REQ-003 SHALL have parameter BASE, default 32'h0000_0000, byte address of word 0.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_request  input  1  initiator requests a transfer.
REQ-007 SHALL have port mem_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port mem_address  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port mem_write_data  input  32  store data.
REQ-010 SHALL have port mem_byte_enable  input  4  per-byte write mask, bit i covers bits [8i+7:8i].
REQ-011 SHALL have port mem_read_data  output  32  load data, registered.
REQ-012 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port mem_error  output  1  out-of-range flag, valid only with mem_ready.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-015 IDLE: mem_request=1 SHALL accept; latch address, write, data, byte enable; go WAIT (LATENCY>1) or RESPOND (LATENCY=1).
REQ-016 WAIT: down-counter loaded with LATENCY-2 at accept; decrement each cycle; at 0 go RESPOND.
REQ-017 Inputs SHALL be ignored outside IDLE; latched values alone determine the transfer.
REQ-018 RESPOND: mem_ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 mem_ready SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-020 Word index = (mem_address - BASE) >> 2, 32-bit unsigned wrap; in range iff index < WORDS.
REQ-021 Read, in range: mem_read_data = stored word, registered on RESPOND entry, valid during mem_ready.
REQ-022 Write, in range: enabled bytes updated on RESPOND-cycle edge; disabled bytes unchanged; mem_read_data unchanged.
REQ-023 Out of range: mem_error=1 with mem_ready; read returns 32'h0; write discarded.
REQ-024 mem_read_data SHALL hold its value until the next completed in-range read or error read.
REQ-025 Write with mem_byte_enable=4'b0000 SHALL complete normally with no storage change.
REQ-026 Back-to-back: request held high through mem_ready SHALL be accepted as new transfer in following IDLE cycle (one idle cycle between transfers).

Reset
REQ-027 reset SHALL force IDLE, counter 0, mem_ready=0, mem_error=0, mem_read_data=32'h0 on the next edge.
REQ-028 reset mid-transfer (WAIT or RESPOND) SHALL abort; pending write SHALL NOT be committed.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 reset SHALL take priority over mem_request on the same edge.

Structure
REQ-031 Shared package SHALL hold the state enum typedef and the LATENCY bounds constants.
REQ-032 Storage SHALL be a sub-module memory_array: byte-masked synchronous write, combinational read, WORDS parameter.
REQ-033 Latched request fields SHALL use the codebase register module with write_enable driven by accept.

Verification
REQ-034 LATENCY=2: write 0xDEADBEEF to 0x10, be=4'hF, then read 0x10 -> mem_ready 2 cycles after each accept, read data 0xDEADBEEF, mem_error=0.
REQ-035 After REQ-034 write 0x00000011 to 0x10, be=4'b0001, read -> 0xDEADBE11.
REQ-036 WORDS=1024: read 0x1000 -> mem_ready with mem_error=1, data 0x0; write 0x1000 then read 0x0FFC -> prior contents unchanged.
REQ-037 Write to 0x20 accepted, reset asserted during WAIT -> no mem_ready; later read 0x20 returns old value.
REQ-038 LATENCY=1, mem_request held high, reads 0x0 then address changed -> mem_ready every other cycle, each response matches address latched at accept.
REQ-039 Address/data toggled during WAIT -> response reflects values latched at accept.
